fifo_nibble_packer: RTL and testbench
=====================================

Name: fifo_nibble_packer

Overview:
- Downstream consumer of the 16-deep x 4-bit synchronous FIFO.
- Drains nibbles from the FIFO read port and packs NIBBLES consecutive nibbles into one wide word, first nibble in the LSBs.
- Presents each word on a valid/ready output handshake.
- Supports a flush request that emits a zero-padded partial word when the FIFO runs dry.

Parameters:
NIBBLES, 4, nibbles per output word (legal 2..8)
CNT_W, 8, width of the delivered-word counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
empty_flag  input  1  FIFO empty indication (combinational from FIFO pointers)
fifo_data  input  4  FIFO registered read data; valid the cycle after rd_en was high
rd_en  output  1  FIFO read request, combinational
flush  input  1  level; pad out the current partial word when FIFO is empty
word_out  output  4*NIBBLES  packed word
word_len  output  4  number of valid nibbles in word_out (1..NIBBLES)
word_valid  output  1  word_out/word_len valid
word_ready  input  1  downstream accepts word when high together with word_valid
word_cnt  output  CNT_W  count of words accepted downstream, wraps

Behaviour:
- Reset: synchronous, active-high (clk, rst).
  - All registers clear in the cycle rst is sampled high: state=REQ, nibble index=0, shift register=0, word_out=0, word_len=0, word_valid=0, word_cnt=0.
  - rd_en is forced 0 while rst=1.
  - Reset mid-word discards captured nibbles.
- States: REQ, CAPT, HOLD.
- REQ:
  - rd_en = ~empty_flag & ~rst.
  - If rd_en is high, go to CAPT.
  - Else if flush=1 and index>0, go to HOLD with a padded word (unfilled nibbles = 0, word_len=index).
  - flush with index=0 is ignored.
- CAPT:
  - rd_en=0.
  - Capture fifo_data into nibble position [index] at the clock edge; index+1.
  - If the new index == NIBBLES, go to HOLD with word_len=NIBBLES; else go to REQ.
- HOLD:
  - word_valid=1; word_out and word_len held stable until handshake.
  - On word_valid & word_ready: word_valid→0 next cycle, index→0, shift register cleared, word_cnt+1 (mod 2^CNT_W), go to REQ.
  - rd_en=0 in HOLD; no prefetch.
- Throughput: one nibble per 2 cycles.
  - Full word latency from first rd_en to word_valid = 2*NIBBLES cycles.
  - Handshake to next rd_en: 1 cycle (REQ).
- Empty mid-word: remain in REQ with rd_en=0, partial word retained indefinitely until data or flush.
- flush sampled only in REQ; ignored in CAPT/HOLD. A read and a flush in the same REQ cycle: the read wins.
- Never reads the FIFO when empty_flag=1; never issues two reads without a capture between them.
- word_ready while word_valid=0 has no effect.

Optional Feature:
- Macro: PACKER_PARITY_EN.
- When defined:
  - Adds output word_parity (1 bit) = XOR of all word_out bits, registered with word_out.
  - Valid whenever word_valid=1; 0 at reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then write 0x1,0x2,0x3,0x4 to the FIFO, word_ready=1 → rd_en pulses 4 times, 2 cycles apart; word_out=0x4321, word_len=4, word_valid for 1 cycle; word_cnt=1.
- 8 nibbles 0x0..0x7 with word_ready=0 → first word 0x3210 held; rd_en stays 0 while in HOLD; raise word_ready → 0x3210 accepted, then 0x7654; word_cnt=2.
- Write 0xA,0xB only, then flush=1 while empty → word_out=0x00BA, word_len=2, word_valid=1; flush with index 0 and empty FIFO → no word.
- Assert rst for 1 cycle after 3 nibbles captured → all outputs 0; then 4 new nibbles 0x5 → word_out=0x5555, no stale data.
- Issue 300 word handshakes with CNT_W=8 → word_cnt=44 (wrap).
- With PACKER_PARITY_EN defined, word 0x0001 → word_parity=1; word 0x0003 → 0.

Source files
------------

// File: rtl/fifo_nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_nibble_packer
//  Purpose  : Drains 4-bit entries from a synchronous FIFO and packs NIBBLES
//             of them (first nibble in the LSBs) into one word. The word is
//             presented on a valid/ready handshake. A flush request pads out
//             a partial word with zeros once the FIFO has run dry.
//  Options  : define PACKER_PARITY_EN to add the word_parity output
//             (XOR of all word_out bits, registered alongside word_out).
//  Revision : 1.0  initial release
// ============================================================================
module fifo_nibble_packer #(
   parameter int NIBBLES = 4,   // nibbles per output word, 2..8
   parameter int CNT_W   = 8    // width of the delivered-word counter
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   empty_flag,
   input  logic [3:0]             fifo_data,
   output logic                   rd_en,
   input  logic                   flush,
   output logic [4*NIBBLES-1:0]   word_out,
   output logic [3:0]             word_len,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic [CNT_W-1:0]       word_cnt
`ifdef PACKER_PARITY_EN
   ,
   output logic                   word_parity
`endif
);

   localparam int         c_word_w  = 4 * NIBBLES;
   localparam logic [3:0] c_nibbles = 4'(NIBBLES);

   // REQ issues a read, CAPT takes the read data, HOLD presents a word.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_CAPT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [3:0]            r_idx;
   logic [c_word_w-1:0]   r_shift;
   logic [c_word_w-1:0]   r_word_out;
   logic [3:0]            r_word_len;
   logic                  r_word_valid;
   logic [CNT_W-1:0]      r_word_cnt;

   logic                  w_rd_en;
   logic                  w_capture;
   logic                  w_load;
   logic                  w_accept;
   logic [3:0]            w_idx_inc;
   logic [c_word_w-1:0]   w_shift_cap;
   logic [c_word_w-1:0]   w_load_word;
   logic [3:0]            w_load_len;

   assign w_idx_inc = r_idx + 4'd1;

   // Shift register image with the incoming nibble dropped into slot r_idx.
   always_comb begin
      w_shift_cap = r_shift;
      for (int i = 0; i < NIBBLES; i++) begin
         if (r_idx == 4'(i)) begin
            w_shift_cap[4*i +: 4] = fifo_data;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode plus the read strobe and datapath enables.
   always_comb begin
      w_state_next = r_state;
      w_rd_en      = 1'b0;
      w_capture    = 1'b0;
      w_load       = 1'b0;
      w_accept     = 1'b0;
      w_load_word  = w_shift_cap;
      w_load_len   = c_nibbles;
      case (r_state)
         S_REQ: begin
            // A pending read always wins over a simultaneous flush.
            w_rd_en = ~empty_flag & ~rst;
            if (w_rd_en) begin
               w_state_next = S_CAPT;
            end else if (flush && (r_idx != 4'd0)) begin
               // Unfilled slots are still zero from the last clear.
               w_state_next = S_HOLD;
               w_load       = 1'b1;
               w_load_word  = r_shift;
               w_load_len   = r_idx;
            end
         end
         S_CAPT: begin
            w_capture = 1'b1;
            if (w_idx_inc == c_nibbles) begin
               w_state_next = S_HOLD;
               w_load       = 1'b1;
            end else begin
               w_state_next = S_REQ;
            end
         end
         S_HOLD: begin
            if (r_word_valid && word_ready) begin
               w_accept     = 1'b1;
               w_state_next = S_REQ;
            end
         end
         default: begin
            w_state_next = S_REQ;
         end
      endcase
   end

   // Packing datapath, presented word and delivered-word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= 4'd0;
         r_shift      <= '0;
         r_word_out   <= '0;
         r_word_len   <= 4'd0;
         r_word_valid <= 1'b0;
         r_word_cnt   <= '0;
      end else begin
         if (w_capture) begin
            r_shift <= w_shift_cap;
            r_idx   <= w_idx_inc;
         end
         if (w_load) begin
            r_word_out   <= w_load_word;
            r_word_len   <= w_load_len;
            r_word_valid <= 1'b1;
         end
         if (w_accept) begin
            r_word_valid <= 1'b0;
            r_idx        <= 4'd0;
            r_shift      <= '0;
            r_word_cnt   <= r_word_cnt + CNT_W'(1);
         end
      end
   end

`ifdef PACKER_PARITY_EN
   logic r_parity;

   // Parity is captured together with the word it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (w_load) begin
         r_parity <= ^w_load_word;
      end
   end

   assign word_parity = r_parity;
`endif

   assign rd_en      = w_rd_en;
   assign word_out   = r_word_out;
   assign word_len   = r_word_len;
   assign word_valid = r_word_valid;
   assign word_cnt   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_nibble_packer
//  Purpose  : Self-checking bench for fifo_nibble_packer. A queue stands in
//             for the FIFO; a reference model groups pushed nibbles into
//             expected words and tracks the expected delivered-word count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_nibble_packer;

   localparam int NIB = 4;
   localparam int CW  = 8;
   localparam int WW  = 4 * NIB;

   logic           clk = 1'b0;
   logic           rst;
   logic           empty_flag;
   logic [3:0]     fifo_data;
   logic           rd_en;
   logic           flush;
   logic [WW-1:0]  word_out;
   logic [3:0]     word_len;
   logic           word_valid;
   logic           word_ready;
   logic [CW-1:0]  word_cnt;
`ifdef PACKER_PARITY_EN
   logic           word_parity;
`endif

   fifo_nibble_packer #(.NIBBLES(NIB), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .empty_flag (empty_flag),
      .fifo_data  (fifo_data),
      .rd_en      (rd_en),
      .flush      (flush),
      .word_out   (word_out),
      .word_len   (word_len),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_cnt   (word_cnt)
`ifdef PACKER_PARITY_EN
      ,
      .word_parity(word_parity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          len;
   } word_t;

   word_t        exp_q[$];
   logic [3:0]   fifo_q[$];
   logic [3:0]   part_q[$];

   int           n_checks  = 0;
   int           n_errors  = 0;
   int           hs        = 0;
   int           hs_cap    = 1000000;
   int           step_no   = 0;
   int           first_rd  = -1;
   int           first_vld = -1;
   logic [CW-1:0] model_cnt = '0;
   logic         prev_rd   = 1'b0;
   logic         rd_pending;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (step %0d)", tag, obs, exp, step_no);
      end
   endtask

   // Close the current partial group into an expected word.
   function automatic void model_emit();
      word_t w;
      w.data = '0;
      w.len  = part_q.size();
      foreach (part_q[i]) w.data[4*i +: 4] = part_q[i];
      exp_q.push_back(w);
      part_q.delete();
   endfunction

   function automatic void model_push(input logic [3:0] n);
      part_q.push_back(n);
      if (part_q.size() == NIB) model_emit();
   endfunction

   function automatic void model_flush();
      if (part_q.size() > 0) model_emit();
   endfunction

   function automatic void model_clear();
      part_q.delete();
      exp_q.delete();
      model_cnt = '0;
   endfunction

   // One clock cycle: drive at negedge, check, then service the FIFO read.
   task automatic step(input bit do_push, input logic [3:0] nib, input bit fl,
                       input bit rdy, input bit rs);
      @(negedge clk);
      rst        = rs;
      flush      = fl;
      word_ready = rdy && (hs < hs_cap);
      if (do_push && fifo_q.size() < 16) begin
         fifo_q.push_back(nib);
         model_push(nib);
      end
      empty_flag = (fifo_q.size() == 0);
      #1;
      if (rs) begin
         check("rst_rd_en", rd_en, 1'b0);
      end else begin
         check("rd_guard", rd_en & (empty_flag | prev_rd), 1'b0);
         check("word_cnt", word_cnt, model_cnt);
         if (rd_en && first_rd < 0) first_rd = step_no;
         if (word_valid) begin
            if (first_vld < 0) first_vld = step_no;
            if (exp_q.size() == 0) begin
               check("spurious_valid", word_valid, 1'b0);
            end else begin
               check("word_out", word_out, exp_q[0].data[WW-1:0]);
               check("word_len", word_len, exp_q[0].len);
`ifdef PACKER_PARITY_EN
               check("word_parity", word_parity, ^exp_q[0].data);
`endif
               if (word_ready) begin
                  void'(exp_q.pop_front());
                  model_cnt++;
                  hs++;
               end
            end
         end
      end
      prev_rd    = rs ? 1'b0 : rd_en;
      rd_pending = rd_en;
      step_no++;
      @(posedge clk);
      #1;
      if (rd_pending && fifo_q.size() > 0) begin
         fifo_data  = fifo_q.pop_front();
         empty_flag = (fifo_q.size() == 0);
      end
   endtask

   // Run until the FIFO is empty and the last capture has settled
   // (optionally until every expected word has been delivered too).
   task automatic drain(input bit rand_rdy, input bit need_words);
      int quiet = 0;
      bit done  = 1'b0;
      for (int k = 0; k < 800; k++) begin
         if (fifo_q.size() == 0) quiet++; else quiet = 0;
         if (quiet > 3 && (!need_words || exp_q.size() == 0)) begin
            done = 1'b1;
            break;
         end
         if (hs >= hs_cap) break;
         step(1'b0, 4'h0, 1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      end
      if (hs < hs_cap) check("drain_timeout", done, 1'b1);
   endtask

   task automatic do_reset(input bit push, input logic [3:0] nib);
      model_clear();
      step(push, nib, 1'b0, 1'b0, 1'b1);
      check("rst_word_out", word_out, '0);
      check("rst_word_len", word_len, 4'd0);
      check("rst_word_valid", word_valid, 1'b0);
      check("rst_word_cnt", word_cnt, '0);
`ifdef PACKER_PARITY_EN
      check("rst_word_parity", word_parity, 1'b0);
`endif
   endtask

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      word_ready = 1'b0;
      empty_flag = 1'b1;
      fifo_data  = 4'h0;
      rd_pending = 1'b0;

      do_reset(1'b0, 4'h0);
      do_reset(1'b0, 4'h0);

      // Basic word and fill latency.
      first_rd  = -1;
      first_vld = -1;
      for (int n = 1; n <= 4; n++) step(1'b1, 4'(n), 1'b0, 1'b1, 1'b0);
      drain(1'b0, 1'b1);
      check("latency", first_vld - first_rd, 2 * NIB);
      check("cnt_first", word_cnt, 1);

      // Back-pressure: two words held behind word_ready=0.
      for (int n = 0; n < 8; n++) step(1'b1, 4'(n), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      check("hold_valid", word_valid, 1'b1);
      check("hold_fifo_left", fifo_q.size(), 4);
      drain(1'b0, 1'b1);
      check("cnt_backpressure", word_cnt, 3);

      // Flush of a two-nibble partial, then a flush with nothing pending.
      step(1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
      drain(1'b0, 1'b0);
      model_flush();
      step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      drain(1'b0, 1'b1);
      check("cnt_flush", word_cnt, 4);
      step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
      drain(1'b0, 1'b1);
      check("cnt_empty_flush", word_cnt, 4);

      // Reset mid-word with a nibble arriving during reset.
      step(1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'h8, 1'b0, 1'b1, 1'b0);
      step(1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
      drain(1'b0, 1'b0);
      do_reset(1'b1, 4'h5);
      for (int n = 0; n < 3; n++) step(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
      drain(1'b0, 1'b1);
      check("cnt_after_reset", word_cnt, 1);

      // Randomized traffic up to 300 handshakes, counter wraps.
      do_reset(1'b0, 4'h0);
      hs     = 0;
      hs_cap = 300;
      for (int it = 0; it < 30000 && hs < hs_cap; it++) begin
         if ((it % 61) == 60) begin
            drain(1'b1, 1'b0);
            if (hs < hs_cap) begin
               model_flush();
               step(1'b0, 4'h0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end
         end else begin
            step(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 1'b0,
                 1'($urandom_range(0, 3) != 0), 1'b0);
         end
      end
      check("hs_reached", hs, 300);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      check("cnt_wrap", word_cnt, 44);
      hs_cap = 1000000;
      drain(1'b0, 1'b1);
      check("leftover_words", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
